// File: rtl/mul_add_row_seq_if.sv
// Bundle between the CIOS row sequencer and its environment: control, a/t word RAM ports, mul_add operands.
// master = sequencer side; slave = RAMs, mul_add and the row controller.
interface mul_add_row_seq_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    logic          start;
    logic [DW-1:0] y_word;
    logic          zero_t;
    logic          busy;
    logic          done;
    logic [AW-1:0] a_raddr;
    logic [DW-1:0] a_rdata;
    logic [AW-1:0] t_raddr;
    logic [DW-1:0] t_rdata;
    logic          t_we;
    logic [AW-1:0] t_waddr;
    logic [DW-1:0] t_wdata;
    logic [DW-1:0] ma_x;
    logic [DW-1:0] ma_y;
    logic [DW-1:0] ma_z;
    logic [DW-1:0] ma_last_c;
    logic [DW-1:0] ma_s;
    logic [DW-1:0] ma_c;

    modport master (
        input  start, y_word, zero_t, a_rdata, t_rdata, ma_s, ma_c,
        output busy, done, a_raddr, t_raddr, t_we, t_waddr, t_wdata,
               ma_x, ma_y, ma_z, ma_last_c
    );

    modport slave (
        output start, y_word, zero_t, a_rdata, t_rdata, ma_s, ma_c,
        input  busy, done, a_raddr, t_raddr, t_we, t_waddr, t_wdata,
               ma_x, ma_y, ma_z, ma_last_c
    );
endinterface

// File: rtl/mul_add_row_seq.sv
// Purpose: word-serial sequencer for one CIOS row, t[0..WORDS+1] <= t + a*y_word, through an external mul_add.
// Latency: WORDS+3 cycles from accepted start to done; one word per cycle in the stream phase.
// Backpressure: none; start is only honoured in IDLE and ignored while busy (including the FINAL cycle).
module mul_add_row_seq #(
    parameter int  DATA_WIDTH = 32,
    parameter int  WORDS      = 128,
    localparam int AW         = $clog2(WORDS + 2)
) (
    input  logic               clk,
    input  logic               rst_n,
    mul_add_row_seq_if.master  bus
);
    localparam int DW = DATA_WIDTH;
    localparam logic [AW-1:0] LAST_J     = AW'(WORDS - 1);
    localparam logic [AW-1:0] TOP_ADDR   = AW'(WORDS);
    localparam logic [AW-1:0] FINAL_ADDR = AW'(WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_TOP,
        S_FINAL
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] j;
    logic [DW-1:0] carry;
    logic [DW-1:0] y_reg;
    logic          zero_reg;
    logic [DW-1:0] t_rd_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (bus.start) state_nxt = S_FILL;
            S_FILL:   state_nxt = S_STREAM;
            S_STREAM: if (j == LAST_J) state_nxt = S_TOP;
            S_TOP:    state_nxt = S_FINAL;
            S_FINAL:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Carry is the only feedback path: one register between successive mul_add words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j        <= '0;
            carry    <= '0;
            y_reg    <= '0;
            zero_reg <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        y_reg    <= bus.y_word;
                        zero_reg <= bus.zero_t;
                        carry    <= '0;
                        j        <= '0;
                    end
                end
                S_STREAM: begin
                    carry <= bus.ma_c;
                    j     <= j + AW'(1);
                end
                S_TOP: begin
                    carry <= bus.ma_c;
                end
                default: begin
                end
            endcase
        end
    end

    assign t_rd_z = zero_reg ? '0 : bus.t_rdata;

    always_comb begin
        bus.busy      = (state != S_IDLE);
        bus.done      = 1'b0;
        bus.a_raddr   = '0;
        bus.t_raddr   = '0;
        bus.t_we      = 1'b0;
        bus.t_waddr   = '0;
        bus.ma_x      = '0;
        bus.ma_y      = '0;
        bus.ma_z      = '0;
        bus.ma_last_c = '0;
        unique case (state)
            S_STREAM: begin
                // Reads run one word ahead of the write, so t[j] is never read and written together.
                bus.a_raddr   = (j == LAST_J) ? '0 : j + AW'(1);
                bus.t_raddr   = j + AW'(1);
                bus.ma_x      = bus.a_rdata;
                bus.ma_y      = y_reg;
                bus.ma_z      = t_rd_z;
                bus.ma_last_c = carry;
                bus.t_we      = 1'b1;
                bus.t_waddr   = j;
            end
            S_TOP: begin
                bus.ma_z      = t_rd_z;
                bus.ma_last_c = carry;
                bus.t_we      = 1'b1;
                bus.t_waddr   = TOP_ADDR;
            end
            S_FINAL: begin
                bus.done    = 1'b1;
                bus.t_we    = 1'b1;
                bus.t_waddr = FINAL_ADDR;
            end
            default: begin
            end
        endcase
    end

    // Kept apart from the operand block: ma_s is a combinational function of ma_x/ma_y/ma_z/ma_last_c.
    always_comb begin
        bus.t_wdata = '0;
        unique case (state)
            S_STREAM, S_TOP: bus.t_wdata = bus.ma_s;
            S_FINAL:         bus.t_wdata = carry;
            default:         bus.t_wdata = '0;
        endcase
    end
endmodule

// File: tb/tb_mul_add_row_seq.sv
// Bench for mul_add_row_seq (8-bit words, 4-word operands) with behavioural RAMs and mul_add.
// Expected row results come from whole-operand integer arithmetic: T + A*y split back into bytes.
module tb_mul_add_row_seq;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int AW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_add_row_seq_if #(.DW(DW), .AW(AW)) bus ();

    mul_add_row_seq #(.DATA_WIDTH(DW), .WORDS(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [2*DW-1:0] mac;
    assign mac = 16'(bus.ma_x) * 16'(bus.ma_y) + 16'(bus.ma_z) + 16'(bus.ma_last_c);
    assign bus.ma_s = mac[DW-1:0];
    assign bus.ma_c = mac[2*DW-1:DW];

    logic [DW-1:0] a_mem [W];
    logic [DW-1:0] t_mem [W+2];
    logic          ld_we;
    logic          ld_sel;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_dat;

    always @(posedge clk) begin
        bus.a_rdata <= (bus.a_raddr < AW'(W)) ? a_mem[bus.a_raddr[1:0]] : '0;
        bus.t_rdata <= (bus.t_raddr < AW'(W + 2)) ? t_mem[bus.t_raddr] : '0;
        if (bus.t_we) t_mem[bus.t_waddr] <= bus.t_wdata;
        else if (ld_we && ld_sel) t_mem[ld_addr] <= ld_dat;
        if (ld_we && !ld_sel) a_mem[ld_addr[1:0]] <= ld_dat;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: cycles since the accepted start (0 = idle) and the row snapshot taken at acceptance.
    int            cnt = 0;
    logic [DW-1:0] a_s [W];
    logic [DW-1:0] t_s [W+2];
    logic [DW-1:0] exp_t [W+2];
    longint        carry_in [W+1];
    logic [DW-1:0] m_y;
    bit            m_zero;

    task automatic model_accept();
        longint tv, av, r, m;
        tv = 0;
        av = 0;
        m_y    = bus.y_word;
        m_zero = bus.zero_t;
        for (int k = 0; k < W + 2; k++) t_s[k] = t_mem[k];
        for (int k = 0; k < W; k++) a_s[k] = a_mem[k];
        for (int k = 0; k <= W; k++) if (!m_zero) tv = tv | (longint'(t_s[k]) << (8 * k));
        for (int k = 0; k < W; k++) av = av | (longint'(a_s[k]) << (8 * k));
        r = tv + av * longint'(m_y);
        for (int k = 0; k < W + 2; k++) exp_t[k] = DW'(r >> (8 * k));
        for (int k = 0; k <= W; k++) begin
            m = (longint'(1) << (8 * k)) - 1;
            carry_in[k] = ((tv & m) + (av & m) * longint'(m_y)) >> (8 * k);
        end
    endtask

    task automatic model_check();
        logic [DW-1:0] ex, ey, ez, ec;
        int jj;
        ex = '0; ey = '0; ez = '0; ec = '0;
        chk("busy", bus.busy, cnt != 0);
        chk("done", bus.done, cnt == W + 3);
        chk("t_we", bus.t_we, cnt >= 2);
        if (cnt >= 2) begin
            chk("t_waddr", bus.t_waddr, cnt - 2);
            chk("t_wdata", bus.t_wdata, exp_t[cnt-2]);
        end
        if (cnt <= 1) begin
            chk("t_raddr_idle", bus.t_raddr, 0);
            chk("a_raddr_idle", bus.a_raddr, 0);
        end
        if (cnt >= 2 && cnt <= W + 1) begin
            jj = cnt - 2;
            ex = a_s[jj];
            ey = m_y;
            ez = m_zero ? '0 : t_s[jj];
            ec = DW'(carry_in[jj]);
            chk("t_raddr", bus.t_raddr, jj + 1);
        end else if (cnt == W + 2) begin
            ez = m_zero ? '0 : t_s[W];
            ec = DW'(carry_in[W]);
        end
        chk("ma_x", bus.ma_x, ex);
        chk("ma_y", bus.ma_y, ey);
        chk("ma_z", bus.ma_z, ez);
        chk("ma_last_c", bus.ma_last_c, ec);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) cnt = 0;
            model_check();
            if (rst_n) begin
                if (cnt == 0) begin
                    if (bus.start) begin
                        model_accept();
                        cnt = 1;
                    end
                end else if (cnt == W + 3) begin
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic load(input bit sel, input int addr, input logic [DW-1:0] d);
        ld_we   = 1'b1;
        ld_sel  = sel;
        ld_addr = AW'(addr);
        ld_dat  = d;
        @(posedge clk);
        #1;
        ld_we = 1'b0;
    endtask

    task automatic load_all(input logic [8*W-1:0] av, input logic [8*(W+2)-1:0] tv);
        for (int k = 0; k < W; k++) load(1'b0, k, av[8*k +: 8]);
        for (int k = 0; k < W + 2; k++) load(1'b1, k, tv[8*k +: 8]);
    endtask

    // extra: cycle (2..7) in which a second start with a different y is pulsed; 0 = none.
    task automatic run_row(input logic [DW-1:0] y, input bit z, input int extra);
        int dc;
        bus.start  = 1'b1;
        bus.y_word = y;
        bus.zero_t = z;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.y_word = 8'($urandom);
        bus.zero_t = 1'($urandom);
        chk("busy_after_start", bus.busy, 1);
        dc = 0;
        for (int k = 1; k <= 20; k++) begin
            bus.start = (k == extra);
            if (k == extra) bus.y_word = ~y;
            @(negedge clk);
            if (bus.done) begin
                dc = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("done_cycle", dc, W + 3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_done", bus.busy, 0);
        for (int k = 0; k < W + 2; k++) chk("ram_t", t_mem[k], exp_t[k]);
    endtask

    logic [8*(W+2)-1:0] lit;
    logic [8*(W+2)-1:0] tv4;
    logic [DW-1:0]      snap [W+2];

    initial begin
        bus.start  = 1'b0;
        bus.y_word = '0;
        bus.zero_t = 1'b0;
        ld_we   = 1'b0;
        ld_sel  = 1'b0;
        ld_addr = '0;
        ld_dat  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_t_we", bus.t_we, 0);
        chk("rst_ma_x", bus.ma_x, 0);
        chk("rst_t_raddr", bus.t_raddr, 0);
        rst_n = 1'b1;

        // Carry chain through every word.
        load_all(32'hFFFF_FFFF, 48'h33_FF_FF_FF_FF_FF);
        run_row(8'hFF, 1'b0, 0);
        lit = 48'h01_FE_FF_FF_FF_00;
        for (int k = 0; k < W + 2; k++) chk("t1_lit", t_mem[k], lit[8*k +: 8]);

        // Back-to-back row straight after done: stale carry of 1 must not leak into t[0].
        run_row(8'h00, 1'b1, 0);
        for (int k = 0; k < W + 2; k++) chk("t6_lit", t_mem[k], 0);

        // First row ignores the preloaded t.
        load_all(32'h0403_0201, 48'hAA_AA_AA_AA_AA_AA);
        run_row(8'h02, 1'b1, 0);
        lit = 48'h00_00_08_06_04_02;
        for (int k = 0; k < W + 2; k++) chk("t2_lit", t_mem[k], lit[8*k +: 8]);

        // Second start mid-row must be ignored.
        load_all(32'($urandom), {16'($urandom), 32'($urandom)});
        run_row(8'h37, 1'b0, 3);

        // y = 0 leaves t intact and clears the top word.
        tv4 = {8'h99, 8'h5A, 32'($urandom)};
        load_all(32'($urandom), tv4);
        run_row(8'h00, 1'b0, 0);
        lit = {8'h00, 8'h5A, tv4[31:0]};
        for (int k = 0; k < W + 2; k++) chk("t4_lit", t_mem[k], lit[8*k +: 8]);

        // Abort during STREAM j=2, then repeat the carry-chain row.
        load_all(32'hFFFF_FFFF, 48'h33_FF_FF_FF_FF_FF);
        bus.start  = 1'b1;
        bus.y_word = 8'hFF;
        bus.zero_t = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_t_we", bus.t_we, 0);
        for (int k = 0; k < W + 2; k++) snap[k] = t_mem[k];
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < W + 2; k++) chk("abort_no_write", t_mem[k], snap[k]);
        chk("abort_partial_t0", t_mem[0], 8'h00);
        chk("abort_untouched_t2", t_mem[2], 8'hFF);
        rst_n = 1'b1;
        load_all(32'hFFFF_FFFF, 48'h33_FF_FF_FF_FF_FF);
        run_row(8'hFF, 1'b0, 0);
        lit = 48'h01_FE_FF_FF_FF_00;
        for (int k = 0; k < W + 2; k++) chk("t5_lit", t_mem[k], lit[8*k +: 8]);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(2) != 0) load_all(32'($urandom), {16'($urandom), 32'($urandom)});
            run_row(8'($urandom), ($urandom_range(3) == 0),
                    ($urandom_range(1) != 0) ? int'($urandom_range(7, 2)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
